// File: rtl/nfc_apb_regs.sv
// ---------------------------------------------------------------------------
// nfc_apb_regs
// APB slave register front-end for the NAND flash controller. Software
// fills a 2-entry command byte buffer, a 5-entry address byte buffer and a
// write-data FIFO. A START streams the buffered bytes into the flash cycle
// FSM (commands first, then addresses), pulses C_Start and waits for
// C_Done. Status and a level interrupt are exposed to software.
//
// Ports:
//   PCLK, PRESETN          clock, asynchronous active-low reset
//   PSEL/PENABLE/PWRITE,
//   PADDR, PWDATA          APB request (PADDR[1:0] ignored)
//   PRDATA, PREADY,
//   PSLVERR                APB response (zero wait states)
//   C_Cmd/C_Cmd_vld        command byte stream to the flash FSM
//   C_Addr/C_Addr_vld      address byte stream to the flash FSM
//   C_Length               transfer length (LEN register)
//   C_Start                one-cycle launch pulse
//   C_Done, C_Status       completion pulse and status byte from the FSM
//   D_Data/D_Vld/D_Rdy     head of the write-data FIFO, popped on Vld&Rdy
//   IRQ                    done & IRQ_EN
// ---------------------------------------------------------------------------
module nfc_apb_regs #(
   parameter int DFIFO_AW = 4
) (
   input  logic        PCLK,
   input  logic        PRESETN,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [7:0]  PADDR,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   output logic [7:0]  C_Cmd,
   output logic        C_Cmd_vld,
   output logic [7:0]  C_Addr,
   output logic        C_Addr_vld,
   output logic [7:0]  C_Length,
   output logic        C_Start,
   input  logic        C_Done,
   input  logic [7:0]  C_Status,
   output logic [7:0]  D_Data,
   output logic        D_Vld,
   input  logic        D_Rdy,
   output logic        IRQ
);
   localparam int CMD_DEPTH  = 2;
   localparam int ADDR_DEPTH = 5;
   localparam int CCW    = $clog2(CMD_DEPTH + 1);
   localparam int ACW    = $clog2(ADDR_DEPTH + 1);
   localparam int IDXW   = 3;
   localparam int DDEPTH = 1 << DFIFO_AW;
   localparam int DCW    = DFIFO_AW + 1;

   localparam logic [5:0] A_CMD  = 6'h00;
   localparam logic [5:0] A_ADDR = 6'h01;
   localparam logic [5:0] A_LEN  = 6'h02;
   localparam logic [5:0] A_CTRL = 6'h03;
   localparam logic [5:0] A_STAT = 6'h04;
   localparam logic [5:0] A_DATA = 6'h05;

   typedef enum logic [2:0] {S_IDLE, S_SEND_CMD, S_SEND_ADDR, S_LAUNCH, S_WAIT} state_t;

   state_t              state_q;
   logic [IDXW-1:0]     idx_q;
   logic [7:0]          cmd_buf_q  [CMD_DEPTH];
   logic [7:0]          addr_buf_q [ADDR_DEPTH];
   logic [CCW-1:0]      cmd_cnt_q;
   logic [ACW-1:0]      addr_cnt_q;
   logic [7:0]          len_q;
   logic                irq_en_q;
   logic                done_q;
   logic [7:0]          dmem [DDEPTH];
   logic [DFIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [DCW-1:0]      dcnt_q;

   logic        busy, op_done, cmd_full, addr_full, dfull, dpop;
   logic        cmd_push, addr_push, len_wr, start_go, flush_go, irqen_wr, done_clr, dpush, err;
   logic [31:0] rdata, status;
   logic [7:0]  cmd_sel, addr_sel;
   logic        unused_bits;

   assign busy      = (state_q != S_IDLE);
   assign op_done   = (state_q == S_WAIT) && C_Done;
   assign cmd_full  = (cmd_cnt_q == CCW'(CMD_DEPTH));
   assign addr_full = (addr_cnt_q == ACW'(ADDR_DEPTH));
   assign dfull     = (dcnt_q == DCW'(DDEPTH));
   assign D_Vld     = (dcnt_q != '0);
   assign D_Data    = dmem[rd_ptr_q];
   assign dpop      = D_Vld && D_Rdy;
   assign C_Length  = len_q;
   assign IRQ       = done_q && irq_en_q;
   assign PREADY    = 1'b1;
   assign PRDATA    = PRESETN ? rdata : '0;
   assign PSLVERR   = PRESETN && err;
   assign unused_bits = ^{PADDR[1:0], PWDATA[31:8]};

   always_comb begin
      status = '0;
      status[0] = busy;
      status[1] = done_q;
      status[2] = cmd_full;
      status[3] = addr_full;
      status[4] = dfull;
      status[5] = ~D_Vld;
      status[15:8] = C_Status;
      status[16 +: DCW] = dcnt_q;
   end

   // Access decode: any rejected access raises err and produces no strobe,
   // so the register/buffer blocks below see no state change at all.
   always_comb begin
      cmd_push = 1'b0; addr_push = 1'b0; len_wr = 1'b0; start_go = 1'b0;
      flush_go = 1'b0; irqen_wr = 1'b0; done_clr = 1'b0; dpush = 1'b0;
      err = 1'b0; rdata = '0;
      if (PSEL && PENABLE) begin
         case (PADDR[7:2])
            A_CMD:  if (PWRITE) begin
                       if (busy || cmd_full) err = 1'b1;
                       else cmd_push = 1'b1;
                    end
            A_ADDR: if (PWRITE) begin
                       if (busy || addr_full) err = 1'b1;
                       else addr_push = 1'b1;
                    end
            A_LEN:  if (PWRITE) begin
                       if (busy) err = 1'b1;
                       else len_wr = 1'b1;
                    end else rdata = {24'b0, len_q};
            A_CTRL: if (PWRITE) begin
                       // START combined with FLUSH would launch an empty buffer.
                       if (busy && (PWDATA[0] || PWDATA[1])) err = 1'b1;
                       else if (PWDATA[0] && (PWDATA[1] || cmd_cnt_q == '0)) err = 1'b1;
                       else begin
                          start_go = PWDATA[0];
                          flush_go = PWDATA[1];
                          irqen_wr = 1'b1;
                       end
                    end else rdata = {29'b0, irq_en_q, 2'b0};
            A_STAT: if (PWRITE) done_clr = PWDATA[1];
                    else rdata = status;
            A_DATA: if (PWRITE) begin
                       if (busy || dfull) err = 1'b1;
                       else dpush = 1'b1;
                    end
            default: err = 1'b1;
         endcase
      end
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         len_q    <= '0;
         irq_en_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         if (len_wr)   len_q    <= PWDATA[7:0];
         if (irqen_wr) irq_en_q <= PWDATA[2];
         // Completion in the same cycle as a W1C keeps done set.
         if (op_done)       done_q <= 1'b1;
         else if (done_clr) done_q <= 1'b0;
      end
   end

   // Byte buffers: counts only change while idle (pushes) or on
   // completion/flush, so the FSM can read them directly during an operation.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         cmd_cnt_q  <= '0;
         addr_cnt_q <= '0;
         for (int i = 0; i < CMD_DEPTH; i++)  cmd_buf_q[i]  <= '0;
         for (int i = 0; i < ADDR_DEPTH; i++) addr_buf_q[i] <= '0;
      end else if (flush_go || op_done) begin
         cmd_cnt_q  <= '0;
         addr_cnt_q <= '0;
      end else begin
         for (int i = 0; i < CMD_DEPTH; i++)
            if (cmd_push && cmd_cnt_q == CCW'(i)) cmd_buf_q[i] <= PWDATA[7:0];
         for (int i = 0; i < ADDR_DEPTH; i++)
            if (addr_push && addr_cnt_q == ACW'(i)) addr_buf_q[i] <= PWDATA[7:0];
         if (cmd_push)  cmd_cnt_q  <= cmd_cnt_q + CCW'(1);
         if (addr_push) addr_cnt_q <= addr_cnt_q + ACW'(1);
      end
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         dcnt_q   <= '0;
      end else if (flush_go) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         dcnt_q   <= '0;
      end else begin
         if (dpush) wr_ptr_q <= wr_ptr_q + DFIFO_AW'(1);
         if (dpop)  rd_ptr_q <= rd_ptr_q + DFIFO_AW'(1);
         if (dpush && !dpop)      dcnt_q <= dcnt_q + DCW'(1);
         else if (!dpush && dpop) dcnt_q <= dcnt_q - DCW'(1);
      end
   end

   always_ff @(posedge PCLK) begin
      if (dpush) dmem[wr_ptr_q] <= PWDATA[7:0];
   end

   always_comb begin
      cmd_sel  = '0;
      addr_sel = '0;
      for (int i = 0; i < CMD_DEPTH; i++)
         if (idx_q == IDXW'(i)) cmd_sel = cmd_buf_q[i];
      for (int i = 0; i < ADDR_DEPTH; i++)
         if (idx_q == IDXW'(i)) addr_sel = addr_buf_q[i];
   end

   // Sequencer. Outputs are registered one step ahead: the state names the
   // phase whose strobe is currently visible, idx_q the next byte to emit.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         C_Cmd      <= '0;
         C_Cmd_vld  <= 1'b0;
         C_Addr     <= '0;
         C_Addr_vld <= 1'b0;
         C_Start    <= 1'b0;
      end else begin
         C_Cmd_vld  <= 1'b0;
         C_Addr_vld <= 1'b0;
         C_Start    <= 1'b0;
         case (state_q)
            S_IDLE: if (start_go) begin
               C_Cmd     <= cmd_buf_q[0];
               C_Cmd_vld <= 1'b1;
               idx_q     <= IDXW'(1);
               state_q   <= S_SEND_CMD;
            end
            S_SEND_CMD: begin
               if (idx_q < IDXW'(cmd_cnt_q)) begin
                  C_Cmd     <= cmd_sel;
                  C_Cmd_vld <= 1'b1;
                  idx_q     <= idx_q + IDXW'(1);
               end else if (addr_cnt_q != '0) begin
                  C_Addr     <= addr_buf_q[0];
                  C_Addr_vld <= 1'b1;
                  idx_q      <= IDXW'(1);
                  state_q    <= S_SEND_ADDR;
               end else begin
                  C_Start <= 1'b1;
                  state_q <= S_LAUNCH;
               end
            end
            S_SEND_ADDR: begin
               if (idx_q < IDXW'(addr_cnt_q)) begin
                  C_Addr     <= addr_sel;
                  C_Addr_vld <= 1'b1;
                  idx_q      <= idx_q + IDXW'(1);
               end else begin
                  C_Start <= 1'b1;
                  state_q <= S_LAUNCH;
               end
            end
            S_LAUNCH: state_q <= S_WAIT;
            S_WAIT:   if (C_Done) state_q <= S_IDLE;
            default:  state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_nfc_apb_regs.sv
// ---------------------------------------------------------------------------
// tb_nfc_apb_regs
// Directed bench for nfc_apb_regs: APB register access, command/address
// streaming and launch timing, buffer overflow, busy rejection, data FIFO
// ordering across pointer wrap, FLUSH and asynchronous reset mid-operation.
// ---------------------------------------------------------------------------
module tb_nfc_apb_regs;
   localparam logic [7:0] R_CMD = 8'h00, R_ADDR = 8'h04, R_LEN = 8'h08;
   localparam logic [7:0] R_CTRL = 8'h0C, R_STAT = 8'h10, R_DATA = 8'h14;

   logic        PCLK = 1'b0, PRESETN = 1'b0;
   logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [7:0]  PADDR = '0;
   logic [31:0] PWDATA = '0;
   logic [31:0] PRDATA;
   logic        PREADY, PSLVERR;
   logic [7:0]  C_Cmd, C_Addr, C_Length;
   logic        C_Cmd_vld, C_Addr_vld, C_Start;
   logic        C_Done = 1'b0;
   logic [7:0]  C_Status = '0;
   logic [7:0]  D_Data;
   logic        D_Vld;
   logic        D_Rdy = 1'b0;
   logic        IRQ;

   nfc_apb_regs #(.DFIFO_AW(4)) dut (
      .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .C_Cmd(C_Cmd), .C_Cmd_vld(C_Cmd_vld),
      .C_Addr(C_Addr), .C_Addr_vld(C_Addr_vld), .C_Length(C_Length),
      .C_Start(C_Start), .C_Done(C_Done), .C_Status(C_Status), .D_Data(D_Data),
      .D_Vld(D_Vld), .D_Rdy(D_Rdy), .IRQ(IRQ)
   );

   always #5 PCLK = ~PCLK;

   int total = 0, bad = 0;
   int cyc = 0, last_acc = 0;
   int start_cnt = 0, start_cyc = 0;
   logic [7:0] cmd_log[$], addr_log[$], exp_cmd[$], exp_addr[$], dmodel[$];
   int cmd_cyc[$], addr_cyc[$];

   always @(posedge PCLK) cyc <= cyc + 1;

   always @(negedge PCLK) begin
      if (C_Cmd_vld)  begin cmd_log.push_back(C_Cmd);   cmd_cyc.push_back(cyc);  end
      if (C_Addr_vld) begin addr_log.push_back(C_Addr); addr_cyc.push_back(cyc); end
      if (C_Start)    begin start_cnt <= start_cnt + 1; start_cyc <= cyc; end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return {2'b0, C_Cmd, C_Addr, C_Length, C_Cmd_vld, C_Addr_vld, C_Start, D_Vld, IRQ, PSLVERR};
   endfunction

   task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d, input logic pop,
                           output logic err, output logic [31:0] rd, output logic [7:0] head);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
      @(posedge PCLK); #1;
      PENABLE = 1'b1; D_Rdy = pop;
      @(negedge PCLK);
      err = PSLVERR; rd = PRDATA; head = D_Data; last_acc = cyc;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; D_Rdy = 1'b0;
      $display("apb %s addr=%02h wdata=%08h rdata=%08h pop=%0d head=%02h slverr=%0d",
               wr ? "wr" : "rd", a, d, rd, pop, head, err);
   endtask

   task automatic apb_wr(input logic [7:0] a, input logic [31:0] d, output logic err);
      logic [31:0] unused_r;
      logic [7:0]  unused_h;
      apb_xfer(1'b1, a, d, 1'b0, err, unused_r, unused_h);
   endtask

   task automatic apb_rd(input logic [7:0] a, output logic [31:0] data, output logic err);
      logic [7:0] unused_h;
      apb_xfer(1'b0, a, 32'h0, 1'b0, err, data, unused_h);
   endtask

   task automatic wait_start(input int prev);
      for (int i = 0; i < 40 && start_cnt == prev; i++) @(posedge PCLK);
      check_val("start_seen", start_cnt, prev + 1);
   endtask

   task automatic pulse_done();
      @(posedge PCLK); #1; C_Done = 1'b1;
      @(posedge PCLK); #1; C_Done = 1'b0;
   endtask

   task automatic clear_logs();
      cmd_log.delete(); addr_log.delete(); cmd_cyc.delete(); addr_cyc.delete();
   endtask

   // Byte order and cycle placement relative to the START access cycle n0.
   task automatic check_stream(input string tag, input int n0);
      int k, m;
      k = exp_cmd.size();
      m = exp_addr.size();
      check_val({tag, "_ncmd"}, cmd_log.size(), k);
      check_val({tag, "_naddr"}, addr_log.size(), m);
      for (int i = 0; i < k && i < cmd_log.size(); i++) begin
         check_val({tag, "_cmd"}, 32'(cmd_log[i]), 32'(exp_cmd[i]));
         check_val({tag, "_cmdcyc"}, cmd_cyc[i], n0 + 1 + i);
      end
      for (int i = 0; i < m && i < addr_log.size(); i++) begin
         check_val({tag, "_addr"}, 32'(addr_log[i]), 32'(exp_addr[i]));
         check_val({tag, "_addrcyc"}, addr_cyc[i], n0 + 1 + k + i);
      end
      check_val({tag, "_startcyc"}, start_cyc, n0 + 1 + k + m);
   endtask

   initial begin
      logic        e;
      logic [31:0] r;
      logic [7:0]  h;
      int          prev, n0;

      // ---------------- reset ----------------
      repeat (3) @(posedge PCLK);
      #1;
      check_val("rst_outs", outs(), 32'h0);
      PRESETN = 1'b1;
      check_val("rst_irq", 32'(IRQ), 32'h0);
      apb_rd(R_STAT, r, e);
      check_val("rst_status", r, 32'h0000_0020);
      check_val("rst_outs2", outs() & 32'hFFFF_FFFE, 32'h0);
      C_Status = 8'hA5;

      // ---------------- main operation ----------------
      apb_wr(R_CMD, 32'h00, e);  check_val("cmd0_err", 32'(e), 0);
      apb_wr(R_CMD, 32'h30, e);  check_val("cmd1_err", 32'(e), 0);
      for (int i = 1; i <= 5; i++) begin
         apb_wr(R_ADDR, 32'(i), e);
         check_val("addr_err", 32'(e), 0);
      end
      apb_wr(R_LEN, 32'h10, e);
      apb_rd(R_STAT, r, e);      check_val("loaded_status", r, 32'h0000_A52C);
      apb_rd(R_LEN, r, e);       check_val("len_rd", r, 32'h10);
      check_val("c_length", 32'(C_Length), 32'h10);
      apb_rd(8'h18, r, e);       check_val("bad_addr_err", 32'(e), 1);
      check_val("bad_addr_data", r, 32'h0);

      clear_logs();
      exp_cmd = '{8'h00, 8'h30};
      exp_addr = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      prev = start_cnt;
      apb_wr(R_CTRL, 32'h5, e);  n0 = last_acc;
      check_val("start_err", 32'(e), 0);
      wait_start(prev);
      check_stream("main", n0);
      apb_rd(R_STAT, r, e);      check_val("busy_status", r, 32'h0000_A52D);
      apb_wr(R_LEN, 32'h99, e);  check_val("len_busy_err", 32'(e), 1);
      check_val("c_length_held", 32'(C_Length), 32'h10);
      apb_rd(R_CTRL, r, e);      check_val("ctrl_rd", r, 32'h4);
      pulse_done();
      apb_rd(R_STAT, r, e);      check_val("done_status", r, 32'h0000_A522);
      check_val("irq_set", 32'(IRQ), 1);
      apb_wr(R_STAT, 32'h2, e);  check_val("w1c_err", 32'(e), 0);
      check_val("irq_clr", 32'(IRQ), 0);
      check_val("one_start", start_cnt, prev + 1);

      // ---------------- buffer overflow ----------------
      apb_wr(R_CMD, 32'h11, e);
      apb_wr(R_CMD, 32'h22, e);
      apb_wr(R_CMD, 32'h33, e);  check_val("cmd_ovf_err", 32'(e), 1);
      for (int i = 0; i < 5; i++) apb_wr(R_ADDR, 32'(8'hA1 + i), e);
      apb_wr(R_ADDR, 32'hA6, e); check_val("addr_ovf_err", 32'(e), 1);
      clear_logs();
      exp_cmd = '{8'h11, 8'h22};
      exp_addr = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
      prev = start_cnt;
      apb_wr(R_CTRL, 32'h5, e);  n0 = last_acc;
      wait_start(prev);
      check_stream("ovf", n0);
      pulse_done();
      apb_wr(R_STAT, 32'h2, e);

      // ---------------- commands only ----------------
      apb_wr(R_CMD, 32'h70, e);
      clear_logs();
      exp_cmd = '{8'h70};
      exp_addr.delete();
      prev = start_cnt;
      apb_wr(R_CTRL, 32'h5, e);  n0 = last_acc;
      wait_start(prev);
      check_stream("cmdonly", n0);
      pulse_done();
      apb_wr(R_STAT, 32'h2, e);

      // ---------------- START rejections ----------------
      prev = start_cnt;
      apb_wr(R_CTRL, 32'h5, e);  check_val("start_empty_err", 32'(e), 1);
      apb_rd(R_STAT, r, e);      check_val("start_empty_status", r, 32'h0000_A520);
      apb_wr(R_CMD, 32'h90, e);
      apb_wr(R_CTRL, 32'h5, e);  check_val("start_ok_err", 32'(e), 0);
      apb_wr(R_CTRL, 32'h5, e);  check_val("start_busy_err", 32'(e), 1);
      repeat (10) @(posedge PCLK);
      check_val("start_busy_count", start_cnt, prev + 1);
      pulse_done();
      apb_wr(R_STAT, 32'h2, e);

      // ---------------- stray C_Done, ignored STATUS bits ----------------
      pulse_done();
      apb_wr(R_STAT, 32'hF1, e); check_val("stat_wr_bits_err", 32'(e), 0);
      apb_rd(R_STAT, r, e);      check_val("stray_done_status", r, 32'h0000_A520);
      check_val("stray_irq", 32'(IRQ), 0);

      // ---------------- data FIFO ----------------
      for (int i = 0; i < 16; i++) begin
         apb_wr(R_DATA, 32'(8'h40 + i), e);
         check_val("dpush_err", 32'(e), 0);
         dmodel.push_back(8'(8'h40 + i));
      end
      apb_wr(R_DATA, 32'h5F, e); check_val("dpush_full_err", 32'(e), 1);
      apb_rd(R_STAT, r, e);      check_val("dfull_status", r, 32'h0010_A510);
      apb_xfer(1'b1, R_DATA, 32'h50, 1'b1, e, r, h);
      check_val("full_pushpop_err", 32'(e), 1);
      check_val("full_pushpop_head", 32'(h), 32'h40);
      void'(dmodel.pop_front());
      apb_rd(R_STAT, r, e);      check_val("d15_status", r, 32'h000F_A500);
      for (int i = 0; i < 20; i++) begin
         apb_xfer(1'b1, R_DATA, 32'(8'h60 + i), 1'b1, e, r, h);
         check_val("pushpop_err", 32'(e), 0);
         check_val("pushpop_head", 32'(h), 32'(dmodel.pop_front()));
         dmodel.push_back(8'(8'h60 + i));
      end
      apb_rd(R_STAT, r, e);      check_val("pushpop_status", r, 32'h000F_A500);
      D_Rdy = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge PCLK);
         check_val("drain_head", 32'(D_Data), 32'(dmodel.pop_front()));
      end
      @(posedge PCLK); #1;
      D_Rdy = 1'b0;
      check_val("drain_vld", 32'(D_Vld), 0);
      apb_rd(R_STAT, r, e);      check_val("drained_status", r, 32'h0000_A520);

      // ---------------- FLUSH ----------------
      apb_wr(R_CMD, 32'h01, e);
      apb_wr(R_CMD, 32'h02, e);
      apb_wr(R_DATA, 32'h99, e);
      apb_rd(R_STAT, r, e);      check_val("preflush_status", r, 32'h0001_A504);
      apb_wr(R_CTRL, 32'h6, e);  check_val("flush_err", 32'(e), 0);
      apb_rd(R_STAT, r, e);      check_val("flush_status", r, 32'h0000_A520);

      // ---------------- reset during SEND_ADDR ----------------
      apb_wr(R_CMD, 32'hC1, e);
      for (int i = 0; i < 5; i++) apb_wr(R_ADDR, 32'(8'hD1 + i), e);
      apb_wr(R_LEN, 32'h10, e);
      apb_wr(R_CTRL, 32'h5, e);
      @(posedge PCLK); #2;
      check_val("in_send_addr_vld", 32'(C_Addr_vld), 1);
      check_val("in_send_addr_byte", 32'(C_Addr), 32'hD1);
      PRESETN = 1'b0;
      #1;
      check_val("midrst_outs", outs(), 32'h0);
      check_val("midrst_prdata", PRDATA, 32'h0);
      clear_logs();
      prev = start_cnt;
      repeat (2) @(posedge PCLK);
      #1;
      PRESETN = 1'b1;
      repeat (15) @(posedge PCLK);
      check_val("no_residual_bytes", cmd_log.size() + addr_log.size(), 0);
      check_val("no_residual_start", start_cnt, prev);
      C_Status = 8'h00;
      apb_rd(R_STAT, r, e);      check_val("postrst_status", r, 32'h0000_0020);
      check_val("postrst_len", 32'(C_Length), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
